// File: rtl/data_memory_line.sv
// Off-chip data memory responder for L1 line fills and write-backs.
// One 256-bit line per request, completed after a fixed LATENCY with a one-cycle ack.
module data_memory_line #(
  parameter int LATENCY     = 10,
  parameter int LINE_ADDR_W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req,
  input  logic         we,
  input  logic [31:0]  addr,
  input  logic [255:0] data_i,
  output logic [255:0] data_o,
  output logic         ack,
  output logic         busy
);

  localparam int         LINES    = 1 << LINE_ADDR_W;
  localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t                 r_state, w_next;
  logic [7:0]             r_cnt;
  logic                   r_we;
  logic [LINE_ADDR_W-1:0] r_idx;
  logic [255:0]           r_wdata;
  logic [255:0]           r_rdata;
  logic [255:0]           r_mem [LINES];

  logic                   w_accept;
  logic                   w_enter_ack;
  logic [LINE_ADDR_W-1:0] w_idx;
  logic [LINE_ADDR_W-1:0] w_rd_idx;
  logic                   w_rd_we;

  assign w_idx       = addr[LINE_ADDR_W+4:5];
  assign w_accept    = (r_state == IDLE) && req;
  assign w_enter_ack = (w_next == ACK) && (r_state != ACK);

  // With LATENCY=1 the ACK is entered straight from IDLE, so the read must
  // use the live request rather than the not-yet-latched copy.
  assign w_rd_idx = (r_state == IDLE) ? w_idx : r_idx;
  assign w_rd_we  = (r_state == IDLE) ? we    : r_we;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (req) w_next = (LATENCY == 1) ? ACK : WAIT;
      WAIT:    if (r_cnt == 8'd1) w_next = ACK;
      ACK:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_we    <= we;
        r_idx   <= w_idx;
        r_wdata <= data_i;
        r_cnt   <= CNT_LOAD;
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt - 8'd1;
      end
      if (w_enter_ack && !w_rd_we) r_rdata <= r_mem[w_rd_idx];
    end
  end

  // Storage is never reset; reset forces IDLE so an aborted write never lands.
  always_ff @(posedge clk) begin
    if (r_state == ACK && r_we) r_mem[r_idx] <= r_wdata;
  end

  assign ack    = (r_state == ACK);
  assign busy   = (r_state != IDLE);
  assign data_o = r_rdata;

endmodule

// File: tb/tb_data_memory_line.sv
// Bench for data_memory_line: vector table, corner-case sequences and a
// randomized run checked against a line-array reference model.
module tb_data_memory_line;

  localparam int LAT = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         req = 1'b0, we = 1'b0;
  logic [31:0]  addr = '0;
  logic [255:0] data_i = '0, data_o;
  logic         ack, busy;

  logic         req1 = 1'b0, we1 = 1'b0;
  logic [31:0]  addr1 = '0;
  logic [255:0] din1 = '0, dout1;
  logic         ack1, busy1;

  data_memory_line #(.LATENCY(LAT), .LINE_ADDR_W(9)) u_dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr),
    .data_i(data_i), .data_o(data_o), .ack(ack), .busy(busy)
  );

  data_memory_line #(.LATENCY(1), .LINE_ADDR_W(9)) u_dut1 (
    .clk(clk), .rst(rst), .req(req1), .we(we1), .addr(addr1),
    .data_i(din1), .data_o(dout1), .ack(ack1), .busy(busy1)
  );

  always #5 clk = ~clk;

  int           n_cmp = 0;
  int           n_bad = 0;
  logic [255:0] mdl [512];
  logic [255:0] exp_last;

  typedef struct {
    bit           w;
    logic [31:0]  a;
    logic [255:0] d;
    logic [255:0] exp;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [31:0] rand_addr(input int idx);
    logic [31:0] a;
    a       = $urandom();
    a[13:5] = 9'(idx);
    return a;
  endfunction

  // One complete request on the LATENCY=10 instance, with timing checks.
  task automatic txn(input bit w, input logic [31:0] a, input logic [255:0] d,
                     input logic [255:0] exp);
    int lat, nb;
    @(negedge clk);
    req = 1'b1; we = w; addr = a; data_i = d;
    @(posedge clk); #1;
    lat = 1; nb = 0;
    while (!ack && lat < LAT + 4) begin
      if (busy) nb++;
      @(posedge clk); #1;
      lat++;
    end
    if (busy) nb++;
    chk("ack_latency", 256'(lat), 256'(LAT));
    chk("busy_cycles", 256'(nb), 256'(LAT));
    req = 1'b0;
    if (w) begin
      chk("wr_keeps_data_o", data_o, exp_last);
      mdl[a[13:5]] = d;
    end else begin
      chk("rd_data", data_o, exp);
      exp_last = exp;
    end
    @(posedge clk); #1;
    chk("idle_after_ack", {254'b0, ack, busy}, 256'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] K, Q, L5, L6, X, d;
    int           nack, c, hold_bad, idx;
    bit           w;

    K  = {8{32'h3C3C_1234}};
    Q  = {8{32'h0F1E_2D3C}};
    L5 = {8{32'h5555_0005}};
    L6 = {8{32'h6666_0006}};
    exp_last = '0;

    tbl[0]  = '{1'b1, 32'h0000_0040, {8{32'hA5A5_A5A5}}, '0};
    tbl[1]  = '{1'b0, 32'h0000_0040, '0, {8{32'hA5A5_A5A5}}};
    tbl[2]  = '{1'b1, 32'h0000_0060, {32'h0, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7}, '0};
    tbl[3]  = '{1'b0, 32'h0000_007C, '0, {32'h0, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7}};
    tbl[4]  = '{1'b0, 32'h0000_4060, '0, {32'h0, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7}};
    tbl[5]  = '{1'b1, 32'h0000_0020, Q, '0};
    tbl[6]  = '{1'b1, 32'h0000_00A0, L5, '0};
    tbl[7]  = '{1'b1, 32'h0000_00C0, L6, '0};
    tbl[8]  = '{1'b0, 32'h0000_00A0, '0, L5};
    tbl[9]  = '{1'b1, 32'h0000_3FE0, {8{32'hC0DE_F00D}}, '0};
    tbl[10] = '{1'b0, 32'hFFFF_FFE0, '0, {8{32'hC0DE_F00D}}};

    // Reset values on both instances.
    #3;
    chk("rst_outs", {data_o, 1'b0}, 257'b0 >> 1);
    chk("rst_ack_busy", {254'b0, ack, busy}, 256'b0);
    chk("rst1_outs", dout1, 256'b0);
    chk("rst1_ack_busy", {254'b0, ack1, busy1}, 256'b0);
    @(posedge clk); #1 rst = 1'b1;

    // Reset during WAIT aborts a write to line 3.
    txn(1'b1, 32'h0000_0060, K, '0);
    txn(1'b0, 32'h0000_0060, '0, K);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h0000_0060; data_i = '1;
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_busy_ack", {254'b0, ack, busy}, 256'b0);
    chk("midrst_data_o", data_o, 256'b0);
    req = 1'b0; we = 1'b0; exp_last = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    nack = 0;
    repeat (LAT + 3) begin
      @(posedge clk); #1;
      if (ack) nack++;
    end
    chk("midrst_no_ack", 256'(nack), 256'b0);
    txn(1'b0, 32'h0000_0060, '0, K);

    for (int i = 0; i < 11; i++) txn(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].exp);

    // Inputs churn during WAIT on a read of line 1.
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h0000_0020; data_i = '0;
    @(posedge clk); #1;
    nack = 0;
    for (int k = 0; k < LAT + 4; k++) begin
      if (ack) begin
        nack++;
        chk("churn_ack_cycle", 256'(k + 1), 256'(LAT));
        chk("churn_rd_data", data_o, Q);
        req = 1'b0; we = 1'b0;
      end else if (k < LAT - 1) begin
        req = ~req; we = 1'b1; addr = $urandom(); data_i = rnd256();
      end
      @(posedge clk); #1;
    end
    chk("churn_one_ack", 256'(nack), 256'd1);
    exp_last = Q;
    txn(1'b0, 32'h0000_0020, '0, Q);

    // Back-to-back: req held across ack with a new address.
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h0000_00A0;
    @(posedge clk); #1;
    c = 1;
    while (!ack && c < LAT + 4) begin @(posedge clk); #1; c++; end
    chk("b2b_first_lat", 256'(c), 256'(LAT));
    chk("b2b_first_data", data_o, L5);
    addr = 32'h0000_00C0;
    c = 0; hold_bad = 0;
    do begin
      @(posedge clk); #1;
      c++;
      if (!ack && data_o !== L5) hold_bad++;
    end while (!ack && c < LAT + 5);
    chk("b2b_gap", 256'(c), 256'(LAT + 1));
    chk("b2b_hold", 256'(hold_bad), 256'b0);
    chk("b2b_second_data", data_o, L6);
    req = 1'b0;
    @(posedge clk); #1;
    chk("b2b_idle", {254'b0, ack, busy}, 256'b0);
    exp_last = L6;

    // LATENCY=1: write then immediate read of the same line.
    for (int j = 0; j < 2; j++) begin
      X = rnd256();
      @(negedge clk);
      req1 = 1'b1; we1 = 1'b1; addr1 = (j == 0) ? 32'h0000_00E0 : 32'h8000_40E0; din1 = X;
      @(posedge clk); #1;
      chk("l1_wr_ack", {254'b0, ack1, busy1}, 256'd3);
      we1 = 1'b0;
      @(posedge clk); #1;
      chk("l1_idle", {254'b0, ack1, busy1}, 256'b0);
      @(posedge clk); #1;
      chk("l1_rd_ack", {254'b0, ack1, busy1}, 256'd3);
      chk("l1_rd_data", dout1, X);
      req1 = 1'b0;
      @(posedge clk); #1;
      chk("l1_done", {254'b0, ack1, busy1}, 256'b0);
    end

    // Randomized traffic against the reference model.
    for (int i = 0; i < 16; i++) txn(1'b1, rand_addr(i), rnd256(), '0);
    for (int i = 0; i < 30; i++) begin
      idx = $urandom_range(0, 15);
      w   = 1'($urandom_range(0, 1));
      if (w) begin
        d = rnd256();
        txn(1'b1, rand_addr(idx), d, '0);
      end else begin
        txn(1'b0, rand_addr(idx), '0, mdl[idx]);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_memory_line.md
Name: data_memory_line

Overview:
- Off-chip data memory model/controller that answers L1 data-cache line fills and write-backs.
- Sits on the external memory side of the L1 cache. Receives 256-bit line requests (32-byte lines) and returns read data or commits write data after a fixed, programmable latency.
- Acts as the responder for the cache controller's miss/write-back requests.

Parameters:
- LATENCY, 10, cycles from request acceptance to the ack cycle; legal range 1..255.
- LINE_ADDR_W, 9, line-index width; storage is 2**LINE_ADDR_W lines of 256 bits (default 16 KB).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-low.
- req  input  1  request strobe from the cache controller.
- we  input  1  1 = line write (write-back), 0 = line read (fill); sampled with req.
- addr  input  32  byte address. addr[4:0] is ignored. Line index = addr[LINE_ADDR_W+4:5]. Upper bits are ignored, so accesses alias/wrap.
- data_i  input  256  write line; bits [255:224] = word 0 ... [31:0] = word 7.
- data_o  output  256  read line, same word ordering.
- ack  output  1  one-cycle completion pulse.
- busy  output  1  high from acceptance through the ack cycle.

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE; counter cleared.
  - ack = 0, busy = 0, data_o = 0.
  - Storage array is not cleared.
  - A request in flight when reset asserts is aborted: no write is committed and no ack is issued.
- FSM states: IDLE, WAIT, ACK.
- IDLE:
  - req is sampled only in IDLE.
  - On a rising edge with req = 1, latch we, the line index and data_i into internal registers, load counter = LATENCY-1, and set busy = 1.
  - Next state: ACK if LATENCY = 1, else WAIT.
- WAIT:
  - Counter decrements each cycle; go to ACK when it reaches 1.
  - Inputs req/we/addr/data_i are ignored, so changes after acceptance have no effect.
- ACK:
  - ack = 1 for exactly one cycle; busy stays 1.
  - Read: data_o is registered on the edge entering ACK, equals the line at the latched index, and holds until the next read reaches ACK. Writes do not change data_o.
  - Write: the latched line is written to storage on the edge leaving ACK.
  - Always returns to IDLE; busy = 0 in IDLE.
- Latency:
  - Request accepted on edge E means ack is high in the cycle after edge E+LATENCY-1, i.e. ack visible LATENCY cycles after acceptance.
  - Minimum spacing between acceptances is LATENCY+1 cycles.
- Handshake rules:
  - The controller holds req (and addr/we/data_i) until it sees ack, and must drop req by the first IDLE edge after ack.
  - If req is still high in IDLE after an ack, it is a new request.
- Read-after-write to the same line: a read accepted after a write's ack returns the new data.
- Only full 256-bit lines are transferred; there are no byte enables.

Test Plan:
- Reset mid-WAIT: accept a write of all-ones to line 3, pull rst low during WAIT -> ack never pulses, busy = 0, data_o = 0; a later read of line 3 returns the pre-reset content, not all-ones.
- Write then read, LATENCY = 10: write line 0xA5A5...A5 at addr 0x0000_0040, then read addr 0x0000_0040 -> write ack 10 cycles after acceptance; read ack 10 cycles after its acceptance with data_o = 0xA5...A5; busy high for 10 cycles each.
- Offset/aliasing: write pattern P at 0x0000_0060, then read 0x0000_007C and 0x0000_4060 (LINE_ADDR_W = 9) -> both return P.
- Input changes during WAIT: accept a read of line 1, then change addr/we/data_i and toggle req -> data_o = line 1 contents, no write occurs, exactly one ack.
- Back-to-back: hold req high across ack with a new address -> the second request is accepted on the first IDLE edge and its ack comes LATENCY+1 cycles after the first ack; data_o holds the first read data until the second ack.
- LATENCY = 1: a read accepted at edge E gives ack in the very next cycle with correct data; a write immediately followed by a read of the same line returns the written data.
